// File: rtl/pipe_ctrl_unit.sv
// rtl/pipe_ctrl_unit.sv - ID decode plus ID/EX, EX/MEM, MEM/WB control pipeline with hazard, branch and MUL stall handling
module pipe_ctrl_unit #(
    parameter int MUL_LAT = 3,
    parameter int REG_AW  = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [6:0]        opcode_i,
    input  logic [6:0]        funct7_i,
    input  logic [REG_AW-1:0] rs1_i,
    input  logic [REG_AW-1:0] rs2_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic              branch_eq_i,
    output logic              stall_o,
    output logic              flush_o,
    output logic              pc_branch_o,
    output logic [1:0]        ex_alu_op_o,
    output logic              ex_alu_src_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic              ex_busy_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic              mem_regwrite_o,
    output logic [REG_AW-1:0] mem_rd_o,
    output logic              wb_regwrite_o,
    output logic              wb_memtoreg_o,
    output logic [REG_AW-1:0] wb_rd_o
);
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] F7_MUL = 7'b0000001;
    localparam logic [3:0] CNT_LOAD = 4'(MUL_LAT - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state, stateNext;
    logic [3:0]        cnt, cntNext;

    logic [1:0]        idAluOp;
    logic              idAluSrc, idRegWrite, idMemToReg, idMemRead, idMemWrite;
    logic              idIsMul, idIsBeq, idUseRs1, idUseRs2;
    logic [REG_AW-1:0] idRd;

    logic              exRegWrite, exMemToReg, exMemRead, exMemWrite;
    logic              memMemToReg;
    logic              busy, loadUse, branchTaken;

    always_comb begin
        idAluOp    = 2'b00;
        idAluSrc   = 1'b0;
        idRegWrite = 1'b0;
        idMemToReg = 1'b0;
        idMemRead  = 1'b0;
        idMemWrite = 1'b0;
        idIsMul    = 1'b0;
        idIsBeq    = 1'b0;
        idUseRs1   = 1'b0;
        idUseRs2   = 1'b0;
        if (valid_i) begin
            case (opcode_i)
                OP_R: begin
                    idIsMul    = (funct7_i == F7_MUL);
                    idAluOp    = idIsMul ? 2'b11 : 2'b10;
                    idRegWrite = 1'b1;
                    idUseRs1   = 1'b1;
                    idUseRs2   = 1'b1;
                end
                OP_I: begin
                    idAluSrc   = 1'b1;
                    idRegWrite = 1'b1;
                    idUseRs1   = 1'b1;
                end
                OP_LW: begin
                    idAluSrc   = 1'b1;
                    idRegWrite = 1'b1;
                    idMemToReg = 1'b1;
                    idMemRead  = 1'b1;
                    idUseRs1   = 1'b1;
                end
                OP_SW: begin
                    idAluSrc   = 1'b1;
                    idMemWrite = 1'b1;
                    idUseRs1   = 1'b1;
                    idUseRs2   = 1'b1;
                end
                OP_BEQ: begin
                    idAluOp    = 2'b01;
                    idIsBeq    = 1'b1;
                    idUseRs1   = 1'b1;
                    idUseRs2   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Only register-writing instructions carry a destination; everything else presents rd=0.
    assign idRd = idRegWrite ? rd_i : '0;

    assign busy    = (state == BUSY);
    assign loadUse = !busy && exMemRead && (ex_rd_o != '0) &&
                     ((idUseRs1 && (rs1_i == ex_rd_o)) || (idUseRs2 && (rs2_i == ex_rd_o)));
    // A beq waiting on a load result must not resolve with a stale comparator value.
    assign branchTaken = !busy && !loadUse && idIsBeq && branch_eq_i;

    assign stall_o     = busy || loadUse;
    assign flush_o     = branchTaken;
    assign pc_branch_o = branchTaken;
    assign ex_busy_o   = busy;

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        if (state == BUSY) begin
            cntNext = cnt - 4'd1;
            if (cnt == 4'd1) begin
                stateNext = IDLE;
            end
        end else if (!stall_o && idIsMul && (MUL_LAT > 1)) begin
            stateNext = BUSY;
            cntNext   = CNT_LOAD;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            ex_alu_op_o    <= 2'b00;
            ex_alu_src_o   <= 1'b0;
            exRegWrite     <= 1'b0;
            exMemToReg     <= 1'b0;
            exMemRead      <= 1'b0;
            exMemWrite     <= 1'b0;
            ex_rd_o        <= '0;
            mem_read_o     <= 1'b0;
            mem_write_o    <= 1'b0;
            mem_regwrite_o <= 1'b0;
            memMemToReg    <= 1'b0;
            mem_rd_o       <= '0;
            wb_regwrite_o  <= 1'b0;
            wb_memtoreg_o  <= 1'b0;
            wb_rd_o        <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            // While the multiply owns EX the ID/EX register holds and MEM sees bubbles.
            if (!busy) begin
                ex_alu_op_o  <= loadUse ? 2'b00 : idAluOp;
                ex_alu_src_o <= loadUse ? 1'b0  : idAluSrc;
                exRegWrite   <= loadUse ? 1'b0  : idRegWrite;
                exMemToReg   <= loadUse ? 1'b0  : idMemToReg;
                exMemRead    <= loadUse ? 1'b0  : idMemRead;
                exMemWrite   <= loadUse ? 1'b0  : idMemWrite;
                ex_rd_o      <= loadUse ? '0    : idRd;
            end
            mem_read_o     <= busy ? 1'b0 : exMemRead;
            mem_write_o    <= busy ? 1'b0 : exMemWrite;
            mem_regwrite_o <= busy ? 1'b0 : exRegWrite;
            memMemToReg    <= busy ? 1'b0 : exMemToReg;
            mem_rd_o       <= busy ? '0   : ex_rd_o;
            wb_regwrite_o  <= mem_regwrite_o;
            wb_memtoreg_o  <= memMemToReg;
            wb_rd_o        <= mem_rd_o;
        end
    end
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb/tb_pipe_ctrl_unit.sv - self-checking bench for pipe_ctrl_unit at MUL_LAT=3 and MUL_LAT=1
module tb_pipe_ctrl_unit;
    typedef struct packed {
        logic [1:0] aluOp;
        logic       aluSrc, rw, m2r, mr, mw, isMul;
        logic [4:0] rd;
    } stage_t;

    typedef struct packed {
        logic       stall, flush, pcb;
        logic [1:0] exAluOp;
        logic       exAluSrc;
        logic [4:0] exRd;
        logic       exBusy, memRead, memWrite, memRegWrite;
        logic [4:0] memRd;
        logic       wbRegWrite, wbMemToReg;
        logic [4:0] wbRd;
    } obs_t;

    logic       clk, rst, valid, beqI;
    logic [6:0] opc, f7;
    logic [4:0] rs1, rs2, rd;

    logic       stallO[2], flushO[2], pcbO[2], exSrcO[2], exBusyO[2];
    logic       memReadO[2], memWriteO[2], memRwO[2], wbRwO[2], wbM2rO[2];
    logic [1:0] exOpO[2];
    logic [4:0] exRdO[2], memRdO[2], wbRdO[2];
    obs_t       obs[2];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int follow = 0;
    int stalls, flushes, wbPulses;

    stage_t mEx[2], mMem[2], mWb[2];
    int     mAge[2];
    int     latOf[2] = '{3, 1};
    bit     pStall[2];
    obs_t   lastObs[2];

    pipe_ctrl_unit #(.MUL_LAT(3), .REG_AW(5)) dut3 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .opcode_i(opc), .funct7_i(f7),
        .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd), .branch_eq_i(beqI),
        .stall_o(stallO[0]), .flush_o(flushO[0]), .pc_branch_o(pcbO[0]),
        .ex_alu_op_o(exOpO[0]), .ex_alu_src_o(exSrcO[0]), .ex_rd_o(exRdO[0]), .ex_busy_o(exBusyO[0]),
        .mem_read_o(memReadO[0]), .mem_write_o(memWriteO[0]), .mem_regwrite_o(memRwO[0]), .mem_rd_o(memRdO[0]),
        .wb_regwrite_o(wbRwO[0]), .wb_memtoreg_o(wbM2rO[0]), .wb_rd_o(wbRdO[0])
    );

    pipe_ctrl_unit #(.MUL_LAT(1), .REG_AW(5)) dut1 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .opcode_i(opc), .funct7_i(f7),
        .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd), .branch_eq_i(beqI),
        .stall_o(stallO[1]), .flush_o(flushO[1]), .pc_branch_o(pcbO[1]),
        .ex_alu_op_o(exOpO[1]), .ex_alu_src_o(exSrcO[1]), .ex_rd_o(exRdO[1]), .ex_busy_o(exBusyO[1]),
        .mem_read_o(memReadO[1]), .mem_write_o(memWriteO[1]), .mem_regwrite_o(memRwO[1]), .mem_rd_o(memRdO[1]),
        .wb_regwrite_o(wbRwO[1]), .wb_memtoreg_o(wbM2rO[1]), .wb_rd_o(wbRdO[1])
    );

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            obs[k] = {stallO[k], flushO[k], pcbO[k], exOpO[k], exSrcO[k], exRdO[k], exBusyO[k],
                      memReadO[k], memWriteO[k], memRwO[k], memRdO[k], wbRwO[k], wbM2rO[k], wbRdO[k]};
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chkObs(input string tag, input obs_t o, input obs_t e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic chkv(input string tag, input int o, input int e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    function automatic void refDecode(input logic v, input logic [6:0] op, input logic [6:0] fn,
                                      input logic [4:0] d, output stage_t s,
                                      output bit u1, output bit u2, output bit ib);
        s = '0; u1 = 0; u2 = 0; ib = 0;
        if (v) begin
            case (op)
                7'b0110011: begin
                    s.isMul = (fn == 7'b0000001);
                    s.aluOp = s.isMul ? 2'b11 : 2'b10;
                    s.rw = 1'b1; s.rd = d; u1 = 1; u2 = 1;
                end
                7'b0010011: begin s.aluSrc = 1'b1; s.rw = 1'b1; s.rd = d; u1 = 1; end
                7'b0000011: begin
                    s.aluSrc = 1'b1; s.rw = 1'b1; s.m2r = 1'b1; s.mr = 1'b1; s.rd = d; u1 = 1;
                end
                7'b0100011: begin s.aluSrc = 1'b1; s.mw = 1'b1; u1 = 1; u2 = 1; end
                7'b1100011: begin s.aluOp = 2'b01; ib = 1; u1 = 1; u2 = 1; end
                default: ;
            endcase
        end
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            mEx[k] = '0; mMem[k] = '0; mWb[k] = '0; mAge[k] = 0;
        end
    endtask

    // One clock: drive ID, compare every output against the stage model, then advance the model.
    task automatic step(input logic v, input logic [6:0] op, input logic [6:0] fn,
                        input logic [4:0] a, input logic [4:0] b, input logic [4:0] d, input logic be);
        stage_t dec;
        bit u1, u2, ib, busy, lu, br;
        bit pBusy[2], pLu[2];
        obs_t e;
        valid = v; opc = op; f7 = fn; rs1 = a; rs2 = b; rd = d; beqI = be;
        refDecode(v, op, fn, d, dec, u1, u2, ib);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            busy = mEx[k].isMul && (mAge[k] < latOf[k]);
            lu   = !busy && mEx[k].mr && (mEx[k].rd != 5'd0) &&
                   ((u1 && a == mEx[k].rd) || (u2 && b == mEx[k].rd));
            br   = !busy && !lu && ib && be;
            e = {busy || lu, br, br, mEx[k].aluOp, mEx[k].aluSrc, mEx[k].rd, busy,
                 mMem[k].mr, mMem[k].mw, mMem[k].rw, mMem[k].rd, mWb[k].rw, mWb[k].m2r, mWb[k].rd};
            chkObs($sformatf("cyc%0d_lat%0d", cyc, latOf[k]), obs[k], e);
            lastObs[k] = obs[k];
            pStall[k] = busy || lu;
            pBusy[k] = busy;
            pLu[k] = lu;
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            mWb[k]  = mMem[k];
            mMem[k] = pBusy[k] ? '0 : mEx[k];
            if (pBusy[k]) begin
                mAge[k]++;
            end else begin
                mEx[k]  = pLu[k] ? '0 : dec;
                mAge[k] = 1;
            end
        end
        cyc++;
        #1;
    endtask

    // Present an instruction until the followed model accepts it; count observed stall/flush cycles.
    task automatic issue(input logic [6:0] op, input logic [6:0] fn, input logic [4:0] a,
                         input logic [4:0] b, input logic [4:0] d, input logic be,
                         output int nStall, output int nFlush);
        bit done;
        nStall = 0; nFlush = 0; done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            step(1'b1, op, fn, a, b, d, be);
            nStall += int'(lastObs[follow].stall);
            nFlush += int'(lastObs[follow].flush);
            if (!pStall[follow]) done = 1;
        end
        chkv("issue_accepted", int'(done), 1);
    endtask

    task automatic bubbles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 7'h00, 7'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    initial begin
        logic [6:0] opTab[7];
        logic [6:0] op, fn;
        opTab = '{7'b0110011, 7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1111111};
        rst = 1'b0; valid = 1'b0; opc = '0; f7 = '0; rs1 = '0; rs2 = '0; rd = '0; beqI = 1'b0;
        #1 rst = 1'b1;
        #2;
        chkObs("reset_lat3", obs[0], '0);
        chkObs("reset_lat1", obs[1], '0);
        modelReset();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // decode sweep, hazard free
        issue(7'b0110011, 7'h00, 5'd1, 5'd2, 5'd10, 1'b0, stalls, flushes);
        issue(7'b0110011, 7'h01, 5'd1, 5'd2, 5'd11, 1'b0, stalls, flushes);
        issue(7'b0010011, 7'h7f, 5'd1, 5'd2, 5'd12, 1'b0, stalls, flushes);
        chkv("mul_stalls_lat3", stalls, 2);
        issue(7'b0000011, 7'h00, 5'd1, 5'd2, 5'd13, 1'b0, stalls, flushes);
        issue(7'b0100011, 7'h00, 5'd1, 5'd2, 5'd14, 1'b0, stalls, flushes);
        issue(7'b1100011, 7'h00, 5'd1, 5'd2, 5'd15, 1'b0, stalls, flushes);
        chkv("beq_not_taken_flush", flushes, 0);
        issue(7'b1111111, 7'h00, 5'd1, 5'd2, 5'd16, 1'b0, stalls, flushes);
        bubbles(4);

        // load-use
        issue(7'b0000011, 7'h00, 5'd1, 5'd0, 5'd5, 1'b0, stalls, flushes);
        issue(7'b0110011, 7'h00, 5'd5, 5'd1, 5'd6, 1'b0, stalls, flushes);
        chkv("lu_stalls", stalls, 1);
        issue(7'b0000011, 7'h00, 5'd1, 5'd0, 5'd0, 1'b0, stalls, flushes);
        issue(7'b0110011, 7'h00, 5'd0, 5'd1, 5'd6, 1'b0, stalls, flushes);
        chkv("lu_x0_stalls", stalls, 0);
        issue(7'b0000011, 7'h00, 5'd1, 5'd0, 5'd5, 1'b0, stalls, flushes);
        issue(7'b0010011, 7'h00, 5'd1, 5'd5, 5'd7, 1'b0, stalls, flushes);
        chkv("lu_rs2_unused_stalls", stalls, 0);

        // branches
        issue(7'b1100011, 7'h00, 5'd3, 5'd4, 5'd0, 1'b1, stalls, flushes);
        chkv("beq_taken_flush", flushes, 1);
        chkv("beq_taken_pcb", int'(lastObs[0].pcb), 1);
        issue(7'b0000011, 7'h00, 5'd1, 5'd0, 5'd5, 1'b0, stalls, flushes);
        issue(7'b1100011, 7'h00, 5'd5, 5'd2, 5'd0, 1'b1, stalls, flushes);
        chkv("beq_after_lu_stalls", stalls, 1);
        chkv("beq_after_lu_flushes", flushes, 1);
        bubbles(4);

        // MUL_LAT=1 timing
        follow = 1;
        issue(7'b0110011, 7'h01, 5'd1, 5'd2, 5'd8, 1'b0, stalls, flushes);
        issue(7'b0110011, 7'h00, 5'd3, 5'd4, 5'd9, 1'b0, stalls, flushes);
        chkv("mul_stalls_lat1", stalls, 0);
        follow = 0;
        bubbles(6);

        // reset in the first BUSY cycle aborts the MUL
        step(1'b1, 7'b0110011, 7'h01, 5'd1, 5'd2, 5'd9, 1'b0);
        chkv("busy_before_reset", int'(obs[0].exBusy), 1);
        rst = 1'b1; valid = 1'b0;
        #1;
        chkObs("rst_busy_lat3", obs[0], '0);
        chkObs("rst_busy_lat1", obs[1], '0);
        modelReset();
        @(posedge clk); #1;
        rst = 1'b0;
        wbPulses = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 7'h00, 7'h00, 5'd0, 5'd0, 5'd0, 1'b0);
            wbPulses += int'(lastObs[0].wbRegWrite);
        end
        chkv("rst_no_wb_pulse", wbPulses, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            int sel;
            sel = int'($urandom_range(0, 6));
            op = opTab[sel];
            if (sel == 6) op = 7'($urandom);
            fn = (sel == 1) ? 7'h01 : (($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h00);
            step(($urandom_range(0, 9) != 0), op, fn, 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
